residue_mem_ofm: RTL and testbench
==================================

Name: residue_mem_ofm

Overview:
- Far end of the sum/threshold packet protocol.
- Accepts 35-bit result packets from the three sum/threshold nodes, stores each neuron's 8-bit residue, and emits spike events to the output feature map.
- From the second timestep on, transmits the stored residue back to the sum/threshold node that owns each neuron. That node needs it as the 11th operand for each neuron.
- Clocked NoC endpoint with valid/ready handshakes at its router port.

Parameters:
- WIDTH, 35, packet width.
- NUM_SUM, 3, number of sum/threshold sources (maps).
- NEURONS, 252, neurons per map per timestep.
- NUM_TS, 2, timesteps per run.
- RES_ADDR, 4'b1111, this node's address.
- SUM_ADDR0 / SUM_ADDR1 / SUM_ADDR2, 4'b0000 / 4'b0100 / 4'b1000, source addresses for map 0/1/2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  input packet valid.
- in_ready  out  1  input accept.
- in_data  in  35  packet {src[34:31], dst[30:27], tag[26:23], spike[22], zeros[21:8], value[7:0]}.
- out_valid  out  1  residue packet valid.
- out_ready  in  1  router accept.
- out_data  out  35  residue packet.
- spk_valid  out  1  one-cycle spike event strobe.
- spk_map  out  2  map of event.
- spk_idx  out  8  neuron index of event.
- spk_ts  out  1  timestep of event.
- spk_bit  out  1  spike value.
- done  out  1  run complete.
- err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset (asynchronous): all outputs 0 except in_ready; ts=0; write counters wcnt[0..2]=0; send pointer=0; state COLLECT. in_ready=1 from the first clock after reset deasserts, and stays 1 (no backpressure). Residue RAM contents are don't-care.
- Transfer occurs on in_valid&in_ready at a rising edge.
- Decode:
  - map m is selected where src==SUM_ADDRm and tag==src and dst==RES_ADDR.
  - Write the residue RAM at address m*NEURONS+wcnt[m] with value[7:0].
  - Increment wcnt[m].
  - The next cycle pulses spk_valid with spk_map=m, spk_idx=old wcnt[m], spk_ts=ts, spk_bit=spike.
- Errors: each drops the packet, leaves state unchanged and pulses err for one cycle.
  - Address mismatch.
  - wcnt[m]==NEURONS (overflow).
  - Any packet while done=1.
- Residue TX:
  - Active while ts>=1 and the send pointer has not wrapped.
  - Order is neuron-major: (n=0,m=0),(0,1),(0,2),(1,0),… up to (NEURONS-1,2).
  - Synchronous RAM read takes 1 cycle, then the output register loads. The first out_valid occurs 2 cycles after the ts increment.
  - out_data={RES_ADDR, SUM_ADDRm, RES_ADDR, 1'b0, 14'b0, residue}.
  - out_data is held stable while out_valid&!out_ready. The pointer advances only on acceptance. Read-ahead may prefetch one entry into a skid register.
- RAM is 1R1W with separate ports. Write of (m,n) in timestep t is always later than the read of (m,n) for t; a same-address same-cycle read/write returns old data (read-first).
- States:
  - COLLECT (ts=0): accept writes only.
  - COLLECT_TX (ts>=1): accept writes and transmit.
  - DONE.
- Timestep advance: all wcnt==NEURONS and (ts==0 or all 3*NEURONS residues sent). Then clear wcnt and the send pointer.
  - If ts==NUM_TS-1, go to DONE and assert done=1, held until reset.
  - Otherwise ts++.
  - An input arriving in the advance cycle is counted for the new timestep.
- Reset mid-operation aborts immediately. out_valid drops asynchronously and no partial state survives.
- Arithmetic: counters are 8-bit unsigned and compared to NEURONS. The RAM address is 10-bit. There is no value arithmetic; the residue is stored verbatim.

Decomposition:
- Package snn_noc_pkg holds:
  - Packet field positions (SRC_MSB/LSB, DST, TAG, SPIKE_BIT, VALUE) and the packed struct typedef noc_pkt_t.
  - Node address constants (sum and res addresses).
  - NEURONS.
- One sub-module, residue_ram: 1R1W synchronous, read-first, depth NUM_SUM*NEURONS, 8-bit.

Test Plan:
- Send 252 packets from SUM_ADDR0 with value=i, spike=i[0] -> 252 spk_valid pulses, spk_map=0, spk_idx=i, spk_bit=i[0]; no out_valid; ts stays 0.
- Complete ts0 for all 3 maps with value=(m*50+i)%256 -> ts=1; first out_data={4'b1111,4'b0000,4'b1111,0,0,8'd0}, second carries SUM_ADDR1 and value 50; 756 packets total.
- Hold out_ready=0 for 10 cycles mid-TX -> out_data unchanged throughout, no residue lost or duplicated (scoreboard).
- In ts1, return the updated value for (0,0) in the same cycle its residue is read -> transmitted residue equals the old ts0 value; RAM then holds the new value.
- Send dst=4'b1110, tag!=src, a 253rd packet from one map, and a packet after done -> each produces a single err pulse; counters and RAM unchanged.
- Assert reset during ts1 TX -> out_valid, done and spk_valid are 0 immediately; in_ready returns to 1 after release; the run restarts at ts=0.

Source files
------------

// File: rtl/snn_noc_pkg.sv
// Packet layout, node addresses and shared types for the sum/threshold NoC.
// Every node on the network imports this package so field positions agree.
package snn_noc_pkg;

  localparam int PKT_W     = 35;
  localparam int SRC_MSB   = 34;
  localparam int SRC_LSB   = 31;
  localparam int DST_MSB   = 30;
  localparam int DST_LSB   = 27;
  localparam int TAG_MSB   = 26;
  localparam int TAG_LSB   = 23;
  localparam int SPIKE_BIT = 22;
  localparam int ZERO_MSB  = 21;
  localparam int ZERO_LSB  = 8;
  localparam int VALUE_MSB = 7;
  localparam int VALUE_LSB = 0;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [3:0]  tag;
    logic        spike;
    logic [13:0] zeros;
    logic [7:0]  value;
  } noc_pkt_t;

  localparam logic [3:0] RES_NODE  = 4'b1111;
  localparam logic [3:0] SUM_NODE0 = 4'b0000;
  localparam logic [3:0] SUM_NODE1 = 4'b0100;
  localparam logic [3:0] SUM_NODE2 = 4'b1000;

  localparam int NEURONS = 252;

  typedef enum logic [1:0] {
    ST_COLLECT    = 2'd0,
    ST_COLLECT_TX = 2'd1,
    ST_DONE       = 2'd2
  } res_state_t;

endpackage

// File: rtl/residue_ram.sv
// Residue store: one write port, one synchronous read port, read-first on
// a same-address collision so a neuron's old residue is never lost.
module residue_ram #(
  parameter int DEPTH = 756,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; every location
  // is written in timestep 0 before it is ever read back.
  // NOTE: non-blocking assignments make the read sample the pre-write
  // contents, which is exactly the read-first behaviour the owner needs.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/residue_mem_ofm.sv
// Far end of the sum/threshold protocol: stores each neuron's residue, emits
// spike events, and from timestep 1 on returns residues to their owners.
module residue_mem_ofm #(
  parameter int         WIDTH     = snn_noc_pkg::PKT_W,
  parameter int         NUM_SUM   = 3,
  parameter int         NEURONS   = snn_noc_pkg::NEURONS,
  parameter int         NUM_TS    = 2,
  parameter logic [3:0] RES_ADDR  = snn_noc_pkg::RES_NODE,
  parameter logic [3:0] SUM_ADDR0 = snn_noc_pkg::SUM_NODE0,
  parameter logic [3:0] SUM_ADDR1 = snn_noc_pkg::SUM_NODE1,
  parameter logic [3:0] SUM_ADDR2 = snn_noc_pkg::SUM_NODE2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             spk_valid,
  output logic [1:0]       spk_map,
  output logic [7:0]       spk_idx,
  output logic             spk_ts,
  output logic             spk_bit,
  output logic             done,
  output logic             err
);

  import snn_noc_pkg::*;

  localparam int DEPTH = NUM_SUM * NEURONS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(NEURONS + 1);
  localparam int TXW   = $clog2(DEPTH + 1);
  localparam int TW    = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;

  localparam logic [CW-1:0]  CNT_FULL = CW'(NEURONS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NEURONS - 1);
  localparam logic [1:0]     MAP_LAST = 2'(NUM_SUM - 1);
  localparam logic [TXW-1:0] TX_TOTAL = TXW'(DEPTH);
  localparam logic [TW-1:0]  TS_LAST  = TW'(NUM_TS - 1);

  function automatic logic [3:0] sum_addr(input logic [1:0] m);
    case (m)
      2'd0:    return SUM_ADDR0;
      2'd1:    return SUM_ADDR1;
      default: return SUM_ADDR2;
    endcase
  endfunction

  function automatic logic [AW-1:0] ram_addr(input logic [1:0] m, input logic [CW-1:0] n);
    return AW'(int'(m) * NEURONS + int'(n));
  endfunction

  res_state_t     state_q, state_d;
  logic [TW-1:0]  ts_q;
  logic [CW-1:0]  wcnt_q [NUM_SUM];

  logic [1:0]     rd_m_q;
  logic [CW-1:0]  rd_n_q;
  logic           rd_wrap_q;
  logic [TXW-1:0] tx_cnt_q;
  logic           ram_vld_q;
  logic [1:0]     ram_map_q;
  logic [7:0]     ram_rdata;

  logic [3:0]     src, dst, tag;
  logic           hit, wr_ok, fire, wr_en;
  logic [1:0]     hit_map;
  logic [CW-1:0]  cur_cnt;
  logic [TW-1:0]  cur_ts;
  logic           all_full, tx_done, last_ts, advance;
  logic           out_load, rd_en;
  logic [AW-1:0]  waddr, raddr;
  noc_pkt_t       tx_pkt;
  logic           unused_zeros;

  assign src          = in_data[SRC_MSB:SRC_LSB];
  assign dst          = in_data[DST_MSB:DST_LSB];
  assign tag          = in_data[TAG_MSB:TAG_LSB];
  assign unused_zeros = ^in_data[ZERO_MSB:ZERO_LSB];

  assign tx_done = (tx_cnt_q == TX_TOTAL);
  assign last_ts = (ts_q == TS_LAST);
  assign advance = all_full &&
                   ((state_q == ST_COLLECT) || (state_q == ST_COLLECT_TX && tx_done));
  assign fire    = in_valid && in_ready;
  assign wr_en   = fire && wr_ok;
  assign done    = (state_q == ST_DONE);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    all_full = 1'b1;
    hit      = 1'b0;
    hit_map  = 2'd0;
    for (int m = 0; m < NUM_SUM; m++) begin
      if (wcnt_q[m] != CNT_FULL) all_full = 1'b0;
      if (src == sum_addr(2'(m)) && tag == src && dst == RES_ADDR) begin
        hit     = 1'b1;
        hit_map = 2'(m);
      end
    end
  end

  // A packet landing in the advance cycle already belongs to the new timestep.
  always_comb begin
    cur_cnt = advance ? '0 : wcnt_q[hit_map];
    cur_ts  = (advance && !last_ts) ? TW'(ts_q + 1'b1) : ts_q;
    wr_ok   = hit && (state_q != ST_DONE) && !(advance && last_ts) && (cur_cnt != CNT_FULL);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT:    if (advance) state_d = last_ts ? ST_DONE : ST_COLLECT_TX;
      ST_COLLECT_TX: if (advance && last_ts) state_d = ST_DONE;
      default:       state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_COLLECT;
    else       state_q <= state_d;
  end

  // Collect side: write counters, timestep and the spike/error strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q      <= '0;
      in_ready  <= 1'b0;
      spk_valid <= 1'b0;
      spk_map   <= '0;
      spk_idx   <= '0;
      spk_ts    <= 1'b0;
      spk_bit   <= 1'b0;
      err       <= 1'b0;
      for (int m = 0; m < NUM_SUM; m++) wcnt_q[m] <= '0;
    end else begin
      in_ready  <= 1'b1;
      spk_valid <= wr_en;
      err       <= fire && !wr_ok;
      if (wr_en) begin
        spk_map <= hit_map;
        spk_idx <= 8'(cur_cnt);
        spk_ts  <= cur_ts[0];
        spk_bit <= in_data[SPIKE_BIT];
      end
      if (advance) begin
        for (int m = 0; m < NUM_SUM; m++) wcnt_q[m] <= '0;
        if (!last_ts) ts_q <= TW'(ts_q + 1'b1);
      end
      if (wr_en) wcnt_q[hit_map] <= CW'(cur_cnt + 1'b1);
    end
  end

  // RAM output register doubles as the skid stage: it is only refilled
  // when the output register is free or draining this cycle.
  assign out_load = ram_vld_q && (!out_valid || out_ready);
  assign rd_en    = (state_q == ST_COLLECT_TX) && !rd_wrap_q && (!ram_vld_q || out_load);
  assign waddr    = ram_addr(hit_map, cur_cnt);
  assign raddr    = ram_addr(rd_m_q, rd_n_q);

  always_comb begin
    tx_pkt       = '0;
    tx_pkt.src   = RES_ADDR;
    tx_pkt.dst   = sum_addr(ram_map_q);
    tx_pkt.tag   = RES_ADDR;
    tx_pkt.value = ram_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_m_q    <= '0;
      rd_n_q    <= '0;
      rd_wrap_q <= 1'b0;
      tx_cnt_q  <= '0;
      ram_vld_q <= 1'b0;
      ram_map_q <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (advance) begin
        rd_m_q    <= '0;
        rd_n_q    <= '0;
        rd_wrap_q <= 1'b0;
        tx_cnt_q  <= '0;
      end else begin
        if (rd_en) begin
          if (rd_m_q == MAP_LAST) begin
            rd_m_q <= '0;
            if (rd_n_q == CNT_LAST) begin
              rd_n_q    <= '0;
              rd_wrap_q <= 1'b1;
            end else begin
              rd_n_q <= CW'(rd_n_q + 1'b1);
            end
          end else begin
            rd_m_q <= 2'(rd_m_q + 1'b1);
          end
        end
        if (out_valid && out_ready) tx_cnt_q <= TXW'(tx_cnt_q + 1'b1);
      end

      if (rd_en)         ram_vld_q <= 1'b1;
      else if (out_load) ram_vld_q <= 1'b0;
      if (rd_en) ram_map_q <= rd_m_q;

      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= tx_pkt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  residue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (8)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (in_data[VALUE_MSB:VALUE_LSB]),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_residue_mem_ofm.sv
// Scoreboard bench for residue_mem_ofm: stimulus pushes expected spikes and
// residues into queues, monitors pop and compare whenever the DUT presents them.
module tb_residue_mem_ofm;

  localparam logic [3:0] RES = 4'b1111;
  localparam int N = 252;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [34:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [34:0] out_data;
  logic        spk_valid;
  logic [1:0]  spk_map;
  logic [7:0]  spk_idx;
  logic        spk_ts, spk_bit, done, err;

  residue_mem_ofm dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .spk_valid(spk_valid), .spk_map(spk_map), .spk_idx(spk_idx),
    .spk_ts(spk_ts), .spk_bit(spk_bit), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int err_seen = 0;
  int rx_cnt = 0;
  int bw [3];
  int bts = 0;
  logic [11:0] spk_q [$];
  logic [34:0] res_q [$];
  logic [11:0] spk_e;
  logic [34:0] res_e;
  logic [34:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sa(input int m);
    case (m)
      0:       return 4'b0000;
      1:       return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [34:0] mkpkt(input logic [3:0] s, input logic [3:0] d,
                                        input logic [3:0] t, input logic sp, input logic [7:0] v);
    return {s, d, t, sp, 14'b0, v};
  endfunction

  // Monitors: spikes, residue packets and error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (spk_valid) begin
        if (spk_q.size() == 0) check("spk_extra", 64'(spk_valid), 64'd0);
        else begin
          spk_e = spk_q.pop_front();
          check("spk_event", {spk_map, spk_idx, spk_ts, spk_bit}, spk_e);
        end
      end
      if (out_valid && res_q.size() == 0) check("out_extra", 64'(out_valid), 64'd0);
      else if (out_valid && out_ready) begin
        res_e = res_q.pop_front();
        check("residue", out_data, res_e);
        rx_cnt++;
      end
      if (err) err_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [34:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_good(input int m, input logic [7:0] v, input logic sp);
    spk_q.push_back({2'(m), 8'(bw[m]), 1'(bts), sp});
    bw[m]++;
    drive(mkpkt(sa(m), RES, sa(m), sp, v));
  endtask

  task automatic push_ts0_residues();
    for (int n = 0; n < N; n++)
      for (int m = 0; m < 3; m++)
        res_q.push_back(mkpkt(RES, sa(m), RES, 1'b0, 8'((m * 50 + n) % 256)));
  endtask

  task automatic wait_rx(input int target, input int limit);
    int t = 0;
    while (rx_cnt < target && t < limit) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  initial begin
    bw = '{0, 0, 0};
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_spk_valid", spk_valid, 0);
    check("rst_err", err, 0);
    cycles(1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // ts0, map 0 only: spikes but no residue traffic
    for (int i = 0; i < N; i++) send_good(0, 8'(i), i[0]);
    cycles(3);
    check("map0_spikes_drained", spk_q.size(), 0);
    check("map0_no_tx", out_valid, 0);

    // finish ts0; one idle advance cycle, then rewrite (0,0) as it is read
    push_ts0_residues();
    for (int m = 1; m < 3; m++)
      for (int i = 0; i < N; i++) send_good(m, 8'((m * 50 + i) % 256), i[0]);
    cycles(1);
    bw  = '{0, 0, 0};
    bts = 1;
    send_good(0, 8'hA5, 1'b1);
    check("out_valid_before_latency", out_valid, 0);
    cycles(1);
    check("first_out_valid_latency", out_valid, 1);

    // stall the router for 10 cycles mid-transfer
    cycles(40);
    out_ready = 1'b0;
    @(negedge clk);
    held = out_data;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_hold", out_data, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    wait_rx(3 * N, 2000);
    check("tx_count", rx_cnt, 3 * N);
    check("tx_queue_empty", res_q.size(), 0);
    cycles(3);
    check("tx_idle", out_valid, 0);
    check("no_err_so_far", err_seen, 0);

    // ts1 errors: bad dst, tag != src, overflow on map 0
    drive(mkpkt(sa(0), 4'b1110, sa(0), 1'b0, 8'h11));
    drive(mkpkt(sa(0), RES, sa(1), 1'b0, 8'h22));
    for (int i = 1; i < N; i++) send_good(0, 8'(i + 1), 1'b0);
    drive(mkpkt(sa(0), RES, sa(0), 1'b1, 8'h33));
    cycles(2);
    check("err_count_ts1", err_seen, 3);
    check("spikes_after_errs", spk_q.size(), 0);

    for (int m = 1; m < 3; m++)
      for (int i = 0; i < N; i++) send_good(m, 8'(i ^ m), i[1]);
    begin
      int t = 0;
      while (!done && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
    end
    check("done_set", done, 1);
    check("ts1_spikes_drained", spk_q.size(), 0);
    drive(mkpkt(sa(1), RES, sa(1), 1'b1, 8'h44));
    cycles(2);
    check("err_after_done", err_seen, 4);
    check("done_held", done, 1);

    // new run, then reset in the middle of ts1 transmission
    reset = 1'b1;
    cycles(2);
    check("done_cleared", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    bw  = '{0, 0, 0};
    bts = 0;
    begin
      int base;
      push_ts0_residues();
      for (int m = 0; m < 3; m++)
        for (int i = 0; i < N; i++) send_good(m, 8'((m * 50 + i) % 256), i[0]);
      base = rx_cnt;
      wait_rx(base + 20, 200);
      check("run2_tx_started", rx_cnt >= base + 20, 1);
    end
    bw  = '{0, 0, 0};
    bts = 1;
    send_good(0, 8'h3C, 1'b1);
    check("pre_reset_spk", spk_valid, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_done", done, 0);
    check("async_rst_spk", spk_valid, 0);
    spk_q.delete();
    res_q.delete();
    cycles(2);
    check("rst_hold_out_valid", out_valid, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rerelease", in_ready, 1);
    bw  = '{0, 0, 0};
    bts = 0;
    send_good(0, 8'h77, 1'b1);
    cycles(4);
    check("restart_spike_seen", spk_q.size(), 0);
    check("restart_no_tx", out_valid, 0);
    check("restart_no_err", err_seen, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
